// File: rtl/me_result_serializer.sv
// Result serializer: buffers motion-estimation result words in a small FIFO and
// shifts each one off-chip as a start marker followed by MSB-first beats on LANES pins.
module me_result_serializer #(
   parameter int RES_W      = 20,
   parameter int LANES      = 1,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             init,
   input  logic [RES_W-1:0]                 res_data,
   input  logic                             res_valid,
   output logic                             res_ready,
   output logic [LANES-1:0]                 ser_out,
   output logic                             ser_frame,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
   output logic [CNT_W-1:0]                 frames_sent
);

   localparam int BEATS  = (RES_W + LANES - 1) / LANES;
   localparam int SH_W   = BEATS * LANES;
   localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

   state_t             state_q, state_d;
   logic [RES_W-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [SH_W-1:0]    shreg_q, shreg_d;
   logic [BEAT_W-1:0]  beat_q, beat_d;
   logic [CNT_W-1:0]   frames_q, frames_d;
   logic [LANES-1:0]   ser_out_q, ser_out_d;
   logic               ser_frame_q, ser_frame_d;
   logic               full, empty, push, pop;
   logic [SH_W-1:0]    head_ld;

   assign full        = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty       = (level_q == '0);
   assign res_ready   = !rst && !full;
   assign push        = res_valid && res_ready && !init;
   assign ser_out     = ser_out_q;
   assign ser_frame   = ser_frame_q;
   assign fifo_level  = level_q;
   assign frames_sent = frames_q;

   always_comb begin
      // Head word left-aligned so any padding lands in the final beat's LSBs.
      head_ld = '0;
      head_ld[SH_W-1 -: RES_W] = mem[rd_ptr_q];

      state_d  = state_q;
      shreg_d  = shreg_q;
      beat_d   = beat_q;
      frames_d = frames_q;
      pop      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shreg_d = head_ld;
               state_d = START;
            end
         end
         START: begin
            state_d = SHIFT;
            beat_d  = '0;
         end
         SHIFT: begin
            if (beat_q == BEAT_W'(BEATS - 1)) begin
               frames_d = frames_q + CNT_W'(1);
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_d = head_ld;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               shreg_d = shreg_q << LANES;
               beat_d  = beat_q + BEAT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // An aborted frame is neither popped further nor counted.
      if (init) begin
         state_d  = IDLE;
         frames_d = frames_q;
         pop      = 1'b0;
      end

      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
      if (init) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end

      // Outputs are registered, so decode them from the state being entered.
      unique case (state_d)
         START:   ser_out_d = '1;
         SHIFT:   ser_out_d = shreg_d[SH_W-1 -: LANES];
         default: ser_out_d = '0;
      endcase
      ser_frame_d = (state_d == SHIFT);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= res_data;
      end
      shreg_q <= shreg_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         beat_q      <= '0;
         frames_q    <= '0;
         ser_out_q   <= '0;
         ser_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         beat_q      <= beat_d;
         frames_q    <= frames_d;
         ser_out_q   <= ser_out_d;
         ser_frame_q <= ser_frame_d;
      end
   end

endmodule

// File: tb/tb_me_result_serializer.sv
// Scoreboard bench for me_result_serializer: accepted words are queued as expected
// frames; a negedge monitor reassembles each serial frame and compares in order.
module tb_me_result_serializer;

   localparam int RES_W      = 20;
   localparam int LANES      = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 16;
   localparam int BEATS      = (RES_W + LANES - 1) / LANES;
   localparam int SH_W       = BEATS * LANES;
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               init = 1'b0;
   logic [RES_W-1:0]   res_data = '0;
   logic               res_valid = 1'b0;
   logic               res_ready;
   logic [LANES-1:0]   ser_out;
   logic               ser_frame;
   logic [LVL_W-1:0]   fifo_level;
   logic [CNT_W-1:0]   frames_sent;

   me_result_serializer #(
      .RES_W(RES_W), .LANES(LANES), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .init(init),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .ser_out(ser_out), .ser_frame(ser_frame),
      .fifo_level(fifo_level), .frames_sent(frames_sent)
   );

   always #5 clk = ~clk;

   int               n_tests = 0;
   int               n_fail = 0;
   logic [RES_W-1:0] expq[$];
   int               exp_frames = 0;
   bit               col_active = 1'b0;
   int               col_beats = 0;
   logic [63:0]      col_word = '0;
   logic [RES_W-1:0] mon_w;
   int               idle_cnt = 0;
   bit               saw_full = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Reference: the word as transmitted, left-aligned with zero padding below it.
   function automatic logic [63:0] frame_bits(input logic [RES_W-1:0] w);
      return 64'(w) << (SH_W - RES_W);
   endfunction

   function automatic logic [63:0] exp_beat(input logic [RES_W-1:0] w, input int k);
      return (frame_bits(w) >> (SH_W - LANES * (k + 1))) & ((64'd1 << LANES) - 1);
   endfunction

   // Monitor: rebuild each frame from the pins, then compare against the queue head.
   always @(negedge clk) begin
      if (col_active) begin
         if (ser_frame) begin
            col_word = (col_word << LANES) | 64'(ser_out);
            col_beats++;
            if (col_beats == BEATS) begin
               col_active = 1'b0;
               exp_frames++;
               if (expq.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got 0x%0h, required no frame", col_word);
               end else begin
                  mon_w = expq.pop_front();
                  check("frame_data", col_word, frame_bits(mon_w));
               end
            end
         end else begin
            check("frame_length", 64'(col_beats), 64'(BEATS));
            col_active = 1'b0;
         end
      end else begin
         check("stray_beat", 64'(ser_frame), 64'd0);
         check("frames_sent", 64'(frames_sent), 64'(exp_frames));
         if (ser_out == '1) begin
            col_active = 1'b1;
            col_beats  = 0;
            col_word   = '0;
         end else begin
            check("idle_out", 64'(ser_out), 64'd0);
            idle_cnt++;
         end
      end
      if (rst || init) begin
         col_active = 1'b0;
         expq.delete();
         if (rst) exp_frames = 0;
      end
   end

   task automatic send(input logic [RES_W-1:0] w);
      int waited = 0;
      res_data  = w;
      res_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (res_ready) begin
            expq.push_back(w);
            break;
         end
         saw_full = 1'b1;
         waited++;
         if (waited > 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: res_ready stuck at 0, required 1");
            break;
         end
      end
      @(posedge clk);
      #1;
      res_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      do begin
         @(negedge clk);
         #1;
         c++;
      end while ((expq.size() != 0 || col_active) && c < 1000);
      n_tests++;
      if (expq.size() != 0 || col_active) begin
         n_fail++;
         $display("FAIL %s: drain timeout, %0d words outstanding, required 0", name, expq.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame(input string name);
      int c = 0;
      while (!ser_frame && c < 50) begin
         @(posedge clk);
         #1;
         c++;
      end
      check(name, 64'(ser_frame), 64'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap;
      logic [RES_W-1:0] w;

      // Reset state
      cycles(3);
      check("ready_in_rst", 64'(res_ready), 64'd0);
      check("level_rst", 64'(fifo_level), 64'd0);
      check("ser_out_rst", 64'(ser_out), 64'd0);
      check("frame_rst", 64'(ser_frame), 64'd0);
      check("count_rst", 64'(frames_sent), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 64'(res_ready), 64'd1);
      @(posedge clk);
      #1;

      // Single word: latency and first beat
      w = 20'hA5F3C;
      send(w);
      check("lat_idle_out", 64'(ser_out), 64'd0);
      check("lat_level", 64'(fifo_level), 64'd1);
      cycles(1);
      check("lat_start_out", 64'(ser_out), (64'd1 << LANES) - 1);
      check("lat_start_frame", 64'(ser_frame), 64'd0);
      check("lat_popped", 64'(fifo_level), 64'd0);
      cycles(1);
      check("lat_beat0_frame", 64'(ser_frame), 64'd1);
      check("lat_beat0_data", 64'(ser_out), exp_beat(w, 0));
      wait_drain("single");
      check("count_1", 64'(frames_sent), 64'd1);

      // All-ones word: last beat carries the zero pad
      w = 20'hFFFFF;
      send(w);
      cycles(1 + BEATS);
      check("pad_last_beat", 64'(ser_out), exp_beat(w, BEATS - 1));
      check("pad_last_value", 64'(ser_out), 64'b110);
      wait_drain("pad");
      check("count_2", 64'(frames_sent), 64'd2);

      // Back-to-back: three consecutive writes, no idle gap
      send(20'h12345);
      send(20'h6789A);
      send(20'hBCDEF);
      check("b2b_level_peak", 64'(fifo_level), 64'd2);
      snap = idle_cnt;
      wait_drain("b2b");
      check("b2b_gap", 64'(idle_cnt - snap), 64'd0);
      check("count_5", 64'(frames_sent), 64'd5);

      // Backpressure: valid held while the FIFO fills
      saw_full = 1'b0;
      for (int i = 0; i < 8; i++) send(RES_W'($urandom));
      check("bp_ready_dropped", 64'(saw_full), 64'd1);
      wait_drain("backpressure");
      check("count_13", 64'(frames_sent), 64'd13);

      // init mid-frame at beat 5 with two words queued
      send(RES_W'($urandom));
      send(RES_W'($urandom));
      send(RES_W'($urandom));
      wait_frame("init_frame_start");
      cycles(5);
      init = 1'b1;
      cycles(1);
      init = 1'b0;
      check("init_out", 64'(ser_out), 64'd0);
      check("init_frame", 64'(ser_frame), 64'd0);
      check("init_level", 64'(fifo_level), 64'd0);
      check("init_count", 64'(frames_sent), 64'd13);
      cycles(30);
      check("init_no_frames", 64'(frames_sent), 64'd13);
      check("init_level_after", 64'(fifo_level), 64'd0);

      // Randomized traffic with random gaps
      for (int i = 0; i < 40; i++) begin
         send(RES_W'($urandom));
         cycles($urandom_range(0, 10));
      end
      wait_drain("random");
      check("count_53", 64'(frames_sent), 64'd53);

      // rst mid-frame clears everything including the counter
      send(RES_W'($urandom));
      send(RES_W'($urandom));
      wait_frame("rst_frame_start");
      cycles(2);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("rst_mid_count", 64'(frames_sent), 64'd0);
      check("rst_mid_level", 64'(fifo_level), 64'd0);
      check("rst_mid_frame", 64'(ser_frame), 64'd0);
      send(20'h0F0F0);
      wait_drain("after_rst");
      check("count_after_rst", 64'(frames_sent), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
